// File: rtl/wb_pkg.sv
// Shared write-back definitions.
// Holds the write-back control-vector bit positions (the MEM/WB pipeline
// register uses the same indices), the architectural register geometry, the
// default stack-pointer reset value, and the write-port request struct.
package wb_pkg;

  // Write-back control vector bit positions
  localparam int WB_REG_WRITE  = 0;
  localparam int WB_SWAP_WRITE = 1;
  localparam int WB_SP_WRITE   = 2;
  localparam int WB_MEM_TO_REG = 3;  // already folded into wb_result upstream
  localparam int WB_VALID      = 4;
  localparam int WB_CTRL_W     = 5;

  // Architectural state geometry
  localparam int GPR_COUNT = 8;
  localparam int GPR_W     = 16;
  localparam int GPR_AW    = $clog2(GPR_COUNT);
  localparam int SP_W      = 32;

  localparam logic [SP_W-1:0] SP_RESET_DEF = 32'h000F_FFFF;

  // Number of decode-side GPR read ports
  localparam int NUM_RD_PORTS = 2;

  // One GPR write request as seen by the array and the bypass muxes
  typedef struct packed {
    logic              en;
    logic [GPR_AW-1:0] addr;
    logic [GPR_W-1:0]  data;
  } gpr_wr_t;

endpackage

// File: rtl/gpr_bypass_mux.sv
// Per-read-port write-first bypass select.
// Returns primary write data on an address hit, else secondary write data on
// a hit, else the committed array value. While reset is asserted the port
// returns zero, so no in-flight write data leaks to decode.
// Ports:
//   rd_en    - 1 when out of reset; gates the whole port
//   rd_addr  - read address
//   wr1/wr2  - primary / secondary write requests (wr1 has priority)
//   arr_data - committed GPR value at rd_addr
//   rd_data  - bypassed read data
module gpr_bypass_mux
  import wb_pkg::*;
(
  input  logic              rd_en,
  input  logic [GPR_AW-1:0] rd_addr,
  input  gpr_wr_t           wr1,
  input  gpr_wr_t           wr2,
  input  logic [GPR_W-1:0]  arr_data,
  output logic [GPR_W-1:0]  rd_data
);

  logic hit1, hit2;

  assign hit1 = wr1.en && (wr1.addr == rd_addr);
  assign hit2 = wr2.en && (wr2.addr == rd_addr);

  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      if (hit1)      rd_data = wr1.data;
      else if (hit2) rd_data = wr2.data;
      else           rd_data = arr_data;
    end
  end

endmodule

// File: rtl/wb_register_file.sv
// Write-back register file: commits MEM/WB results into eight 16-bit GPRs
// and the 32-bit stack pointer, and serves decode through two combinational
// GPR read ports plus an SP port, all with same-cycle write bypass.
// Ports:
//   clk, reset        - clock; asynchronous active-low reset
//   wb_ctrl           - write-back control vector (see wb_pkg bit indices)
//   wb_result, wb_dst - primary write data / destination
//   wb_data2, wb_dst2 - secondary (SWAP) write data / destination
//   wb_sp             - new stack-pointer value
//   rd_addr_a/b       - decode read addresses
//   rd_data_a/b       - bypassed read data
//   sp_out            - bypassed stack pointer
module wb_register_file
  import wb_pkg::*;
#(
  parameter int              NUMBER_CONTROL_SIGNALS = WB_CTRL_W,
  parameter logic [SP_W-1:0] SP_RESET               = SP_RESET_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUMBER_CONTROL_SIGNALS-1:0] wb_ctrl,
  input  logic [GPR_W-1:0]                  wb_result,
  input  logic [GPR_AW-1:0]                 wb_dst,
  input  logic [GPR_W-1:0]                  wb_data2,
  input  logic [GPR_AW-1:0]                 wb_dst2,
  input  logic [SP_W-1:0]                   wb_sp,
  input  logic [GPR_AW-1:0]                 rd_addr_a,
  input  logic [GPR_AW-1:0]                 rd_addr_b,
  output logic [GPR_W-1:0]                  rd_data_a,
  output logic [GPR_W-1:0]                  rd_data_b,
  output logic [SP_W-1:0]                   sp_out
);

  logic [GPR_COUNT-1:0][GPR_W-1:0] gpr_q;
  logic [SP_W-1:0]                 sp_q;

  gpr_wr_t wr1, wr2;
  logic    sp_wr;

  // Every control bit feeds the enables except MEM_TO_REG and any extra
  // upper bits; fold the whole vector into a sink to keep lint quiet.
  logic ctrl_unused;
  assign ctrl_unused = ^wb_ctrl;

  assign wr1.en   = wb_ctrl[WB_VALID] & wb_ctrl[WB_REG_WRITE];
  assign wr1.addr = wb_dst;
  assign wr1.data = wb_result;
  assign wr2.en   = wb_ctrl[WB_VALID] & wb_ctrl[WB_SWAP_WRITE];
  assign wr2.addr = wb_dst2;
  assign wr2.data = wb_data2;
  assign sp_wr    = wb_ctrl[WB_VALID] & wb_ctrl[WB_SP_WRITE];

  // GPR array. The primary write is applied last so it wins a same-address
  // collision with the secondary port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpr_q <= '0;
    end else begin
      if (wr2.en) gpr_q[wr2.addr] <= wr2.data;
      if (wr1.en) gpr_q[wr1.addr] <= wr1.data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     sp_q <= SP_RESET;
    else if (sp_wr) sp_q <= wb_sp;
  end

  // Read ports
  logic [NUM_RD_PORTS-1:0][GPR_AW-1:0] rd_addr;
  logic [NUM_RD_PORTS-1:0][GPR_W-1:0]  rd_data;

  assign rd_addr = {rd_addr_b, rd_addr_a};

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    gpr_bypass_mux u_mux (
      .rd_en    (reset),
      .rd_addr  (rd_addr[p]),
      .wr1      (wr1),
      .wr2      (wr2),
      .arr_data (gpr_q[rd_addr[p]]),
      .rd_data  (rd_data[p])
    );
  end

  assign rd_data_a = rd_data[0];
  assign rd_data_b = rd_data[1];

  // sp_q already sits at SP_RESET during reset; only the bypass needs gating.
  assign sp_out = (reset && sp_wr) ? wb_sp : sp_q;

endmodule

// File: tb/tb_wb_register_file.sv
`timescale 1ns/1ps
module tb_wb_register_file;

  localparam logic [31:0] SP_RST = 32'h000F_FFFF;

  logic        clk, reset;
  logic [4:0]  wb_ctrl;
  logic [15:0] wb_result, wb_data2;
  logic [2:0]  wb_dst, wb_dst2;
  logic [31:0] wb_sp;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic [31:0] sp_out;

  wb_register_file #(.NUMBER_CONTROL_SIGNALS(5), .SP_RESET(SP_RST)) dut (
    .clk(clk), .reset(reset), .wb_ctrl(wb_ctrl),
    .wb_result(wb_result), .wb_dst(wb_dst),
    .wb_data2(wb_data2), .wb_dst2(wb_dst2), .wb_sp(wb_sp),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .sp_out(sp_out)
  );

  // Clock starts late so the reset-clear check sees no clock edge at all.
  initial begin
    clk = 1'b0;
    #50;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state as plain arrays
  logic [15:0] m_gpr [8];
  logic [31:0] m_sp;

  function automatic bit v_reg();  return wb_ctrl[4] && wb_ctrl[0]; endfunction
  function automatic bit v_swap(); return wb_ctrl[4] && wb_ctrl[1]; endfunction
  function automatic bit v_sp();   return wb_ctrl[4] && wb_ctrl[2]; endfunction

  function automatic logic [15:0] m_read(input logic [2:0] a);
    if (!reset) return 16'h0;
    if (v_reg() && a == wb_dst)   return wb_result;
    if (v_swap() && a == wb_dst2) return wb_data2;
    return m_gpr[a];
  endfunction

  function automatic logic [31:0] m_spo();
    if (!reset) return SP_RST;
    return v_sp() ? wb_sp : m_sp;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_gpr[i] = 16'h0;
    m_sp = SP_RST;
  endtask

  // Let the posedge commit, mirror it in the model, return to the negedge.
  task automatic commit();
    @(posedge clk);
    if (reset) begin
      if (v_swap()) m_gpr[wb_dst2] = wb_data2;
      if (v_reg())  m_gpr[wb_dst]  = wb_result;
      if (v_sp())   m_sp = wb_sp;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [4:0]  ctrl;
    logic [15:0] res;
    logic [2:0]  dst;
    logic [15:0] d2;
    logic [2:0]  dst2;
    logic [31:0] sp;
    logic [2:0]  ra, rb;
    logic [15:0] ea, eb;
    logic [31:0] esp;
  } vec_t;

  vec_t tbl [10];

  initial begin
    //          ctrl      res       dst  d2        dst2 sp            ra rb ea        eb        esp
    tbl[0] = '{5'b10001, 16'hBEEF, 3'd3, 16'h0000, 3'd0, 32'h0,       3, 0, 16'hBEEF, 16'h0000, SP_RST};
    tbl[1] = '{5'b00000, 16'h0000, 3'd0, 16'h0000, 3'd0, 32'h0,       3, 3, 16'hBEEF, 16'hBEEF, SP_RST};
    tbl[2] = '{5'b10011, 16'h1111, 3'd5, 16'h2222, 3'd5, 32'h0,       5, 5, 16'h1111, 16'h1111, SP_RST};
    tbl[3] = '{5'b00000, 16'h0000, 3'd0, 16'h0000, 3'd0, 32'h0,       5, 3, 16'h1111, 16'hBEEF, SP_RST};
    tbl[4] = '{5'b10011, 16'h1111, 3'd5, 16'h2222, 3'd6, 32'h0,       5, 6, 16'h1111, 16'h2222, SP_RST};
    tbl[5] = '{5'b00000, 16'h0000, 3'd0, 16'h0000, 3'd0, 32'h0,       5, 6, 16'h1111, 16'h2222, SP_RST};
    tbl[6] = '{5'b10100, 16'h0000, 3'd0, 16'h0000, 3'd0, 32'h000F_FFFD, 0, 1, 16'h0000, 16'h0000, 32'h000F_FFFD};
    tbl[7] = '{5'b00000, 16'h0000, 3'd0, 16'h0000, 3'd0, 32'h0,       0, 1, 16'h0000, 16'h0000, 32'h000F_FFFD};
    tbl[8] = '{5'b01111, 16'hFFFF, 3'd2, 16'h1234, 3'd2, 32'h0,       2, 4, 16'h0000, 16'h0000, 32'h000F_FFFD};
    tbl[9] = '{5'b00000, 16'h0000, 3'd0, 16'h0000, 3'd0, 32'h0,       2, 5, 16'h0000, 16'h1111, 32'h000F_FFFD};

    wb_ctrl = '0; wb_result = '0; wb_dst = '0; wb_data2 = '0; wb_dst2 = '0;
    wb_sp = '0; rd_addr_a = '0; rd_addr_b = '0;
    reset = 1'b1;

    // Reset clears without any clock edge; bypass is gated during reset
    #3 reset = 1'b0;
    m_reset();
    wb_ctrl = 5'b10101; wb_dst = 3'd3; wb_result = 16'h5A5A; wb_sp = 32'h1234_5678;
    rd_addr_a = 3'd3;
    #1;
    check("rst_bypass_a", {16'h0, rd_data_a}, 32'h0);
    check("rst_bypass_sp", sp_out, SP_RST);
    wb_ctrl = '0;
    #1 reset = 1'b1;
    for (int i = 0; i < 8; i += 2) begin
      rd_addr_a = 3'(i); rd_addr_b = 3'(i + 1);
      #1;
      check("rst_a", {16'h0, rd_data_a}, 32'h0);
      check("rst_b", {16'h0, rd_data_b}, 32'h0);
    end
    check("rst_sp", sp_out, SP_RST);

    @(negedge clk);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      wb_ctrl = tbl[i].ctrl; wb_result = tbl[i].res; wb_dst = tbl[i].dst;
      wb_data2 = tbl[i].d2; wb_dst2 = tbl[i].dst2; wb_sp = tbl[i].sp;
      rd_addr_a = tbl[i].ra; rd_addr_b = tbl[i].rb;
      #2;
      check($sformatf("tbl%0d_a", i), {16'h0, rd_data_a}, {16'h0, tbl[i].ea});
      check($sformatf("tbl%0d_b", i), {16'h0, rd_data_b}, {16'h0, tbl[i].eb});
      check($sformatf("tbl%0d_sp", i), sp_out, tbl[i].esp);
      commit();
    end

    // Reset dropping during a pending write: the write is lost
    wb_ctrl = 5'b10001; wb_dst = 3'd1; wb_result = 16'hAAAA; rd_addr_a = 3'd1;
    #1 check("midwr_bypass", {16'h0, rd_data_a}, 32'h0000_AAAA);
    #1 reset = 1'b0;
    m_reset();
    #1 check("midwr_rst_a", {16'h0, rd_data_a}, 32'h0);
    @(posedge clk);
    #1 check("midwr_edge_a", {16'h0, rd_data_a}, 32'h0);
    wb_ctrl = '0;
    reset = 1'b1;
    rd_addr_b = 3'd5;
    #1;
    check("midwr_r1", {16'h0, rd_data_a}, 32'h0);
    check("midwr_r5", {16'h0, rd_data_b}, 32'h0);
    check("midwr_sp", sp_out, SP_RST);
    @(negedge clk);

    // Randomized traffic against the model; destinations often collide
    for (int n = 0; n < 400; n++) begin
      wb_ctrl   = 5'($urandom);
      wb_result = 16'($urandom);
      wb_data2  = 16'($urandom);
      wb_dst    = 3'($urandom);
      wb_dst2   = ($urandom_range(0, 3) == 0) ? wb_dst : 3'($urandom);
      wb_sp     = $urandom;
      rd_addr_a = ($urandom_range(0, 2) == 0) ? wb_dst  : 3'($urandom);
      rd_addr_b = ($urandom_range(0, 2) == 0) ? wb_dst2 : 3'($urandom);
      #2;
      check("rnd_a", {16'h0, rd_data_a}, {16'h0, m_read(rd_addr_a)});
      check("rnd_b", {16'h0, rd_data_b}, {16'h0, m_read(rd_addr_b)});
      check("rnd_sp", sp_out, m_spo());
      commit();
    end

    // Final sweep of committed state with no writes in flight
    wb_ctrl = '0;
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
      #1;
      check("final_a", {16'h0, rd_data_a}, {16'h0, m_gpr[i]});
      check("final_b", {16'h0, rd_data_b}, {16'h0, m_gpr[7 - i]});
    end
    check("final_sp", sp_out, m_sp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_register_file.md
Name: wb_register_file

Overview:
- Write-back end of the MEM/WB stage boundary.
- Consumes the registered MEM/WB outputs (control vector, result, destination number, stack pointer) and commits them to architectural state: eight 16-bit general-purpose registers and one 32-bit stack pointer.
- Serves the decode stage through two asynchronous read ports and one SP read port.
- Bypasses same-cycle write-back data so decode never reads stale values.

Parameters:
- NUMBER_CONTROL_SIGNALS, 5, width of the incoming write-back control vector.
- SP_RESET, 32'h000F_FFFF, stack-pointer value after reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; clears all state.
- wb_ctrl  input  NUMBER_CONTROL_SIGNALS  write-back control vector from MEM/WB.
- wb_result  input  16  primary write data.
- wb_dst  input  3  primary destination register number.
- wb_data2  input  16  secondary write data (SWAP).
- wb_dst2  input  3  secondary destination register number.
- wb_sp  input  32  new stack-pointer value from MEM/WB.
- rd_addr_a  input  3  decode read port A address.
- rd_addr_b  input  3  decode read port B address.
- rd_data_a  output  16  port A data.
- rd_data_b  output  16  port B data.
- sp_out  output  32  current stack pointer, bypassed.

Behaviour:
- Interface: one clock `clk`. Reset `reset` is asynchronous and active-low. On `reset` low, all eight GPRs go to 16'h0000 and SP goes to SP_RESET immediately, independent of `clk`.
- Control bit positions (package constants):
  - bit 0 WB_REG_WRITE
  - bit 1 WB_SWAP_WRITE
  - bit 2 WB_SP_WRITE
  - bit 3 WB_MEM_TO_REG (ignored here; already resolved into wb_result)
  - bit 4 WB_VALID
- A write takes effect only when WB_VALID=1. With WB_VALID=0 no state changes, whatever the other bits are.
- Port 1 write: at posedge clk, if WB_VALID and WB_REG_WRITE, GPR[wb_dst] <= wb_result.
- Port 2 write: at the same posedge, if WB_VALID and WB_SWAP_WRITE, GPR[wb_dst2] <= wb_data2.
- Same-address conflict: if both write ports are enabled and wb_dst == wb_dst2, port 1 (wb_result) wins.
- SP write: at posedge, if WB_VALID and WB_SP_WRITE, SP <= wb_sp; otherwise SP holds.
- Read ports are combinational, with write-first bypass. For each port, in priority order:
  - If port 1 write is enabled and the address matches wb_dst, return wb_result.
  - Else if port 2 write is enabled and the address matches wb_dst2, return wb_data2.
  - Else return GPR[addr].
- sp_out = wb_sp when an SP write is enabled, else SP.
- Latency: committed state is visible through the array one cycle after the write edge. The bypass makes it visible in the same cycle.
- All 8 registers are writable; R0 is not hardwired.
- While reset is asserted, reads return 0 (and SP_RESET on sp_out), bypass included. The bypass is gated by reset high.
- Reset asserted mid-write: reset dominates and the pending write is lost.
- No X propagation: undriven control bits are treated as 0 by the bench.

Decomposition:
- Shared package `wb_pkg` holds:
  - control bit index constants WB_REG_WRITE..WB_VALID
  - GPR_COUNT=8, GPR_W=16, SP_W=32
  - a default SP_RESET constant
- The MEM/WB register uses the same indices.
- One natural sub-module, `gpr_bypass_mux`: the per-port priority bypass select, instantiated twice.

Test Plan:
1. Reset: hold reset=0 mid-cycle, release → rd_data_a/b = 16'h0000 for all addresses, sp_out = 32'h000F_FFFF, with no clock edge needed for the clear.
2. Write then read: wb_ctrl={VALID,REG_WRITE}, wb_dst=3, wb_result=16'hBEEF; same cycle rd_addr_a=3 → rd_data_a=16'hBEEF (bypass). Next cycle with ctrl=0 → still 16'hBEEF.
3. SWAP with collision: REG_WRITE+SWAP_WRITE, wb_dst=wb_dst2=5, wb_result=16'h1111, wb_data2=16'h2222 → R5=16'h1111. Repeat with wb_dst2=6 → R5=16'h1111, R6=16'h2222, both readable on ports A/B in the same cycle.
4. SP: SP_WRITE, wb_sp=32'h000F_FFFD → sp_out shows 32'h000F_FFFD immediately and holds it after the edge. Next cycle with SP_WRITE=0 and wb_sp=0 → sp_out still 32'h000F_FFFD.
5. Invalid gating: REG_WRITE=1, VALID=0, wb_dst=2, wb_result=16'hFFFF → R2 unchanged (0), and no bypass to rd_data_a when rd_addr_a=2.
6. Reset mid-write: write to R1 with 16'hAAAA while reset drops before the edge → R1=0 after the edge and reset release.
